// File: rtl/rm_lane_alloc.sv
// rm_lane_alloc: allocator and lifecycle controller for the runtime-monitor lane array.
//
// Issue requests (LW/SW) are granted to the lowest-index FREE lane. The lane stays BUSY
// until its instruction commits (tag match) or the pipeline flushes. It then spends one
// cycle in CLEAR, driving its lane reset, and returns to FREE. The first rule violation
// seen on any BUSY lane is captured and held until cleared.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   ins_valid_i/itype/id    issue request, instruction type, scoreboard tag
//   ins_ready_o             a lane is FREE and no flush is in progress
//   commit_valid_i/id       commit of the instruction carrying commit_id_i
//   flush_i, stall_i        pipeline flush / stall
//   monitor_i               per-lane rule outputs, lane k at [k*NUM_RULES +: NUM_RULES]
//   viol_clr_i              clears the captured violation
//   alloc_valid_o           one-hot (or zero) per-lane allocation strobe
//   alloc_itype_o           instruction type broadcast to all lanes
//   lane_reset_o            per-lane reset, high while the lane is in CLEAR
//   halt_o                  registered copy of stall_i
//   busy_cnt_o              number of lanes not FREE
//   violation_o             sticky violation flag
//   violation_lane_o        lane that raised the captured violation
module rm_lane_alloc #(
  parameter int NUM_LANES = 4,
  parameter int NUM_RULES = 16,
  parameter int ID_W      = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             ins_valid_i,
  input  logic                             ins_itype_i,
  input  logic [ID_W-1:0]                  ins_id_i,
  output logic                             ins_ready_o,
  input  logic                             commit_valid_i,
  input  logic [ID_W-1:0]                  commit_id_i,
  input  logic                             flush_i,
  input  logic                             stall_i,
  input  logic [NUM_LANES*NUM_RULES-1:0]   monitor_i,
  input  logic                             viol_clr_i,
  output logic [NUM_LANES-1:0]             alloc_valid_o,
  output logic                             alloc_itype_o,
  output logic [NUM_LANES-1:0]             lane_reset_o,
  output logic                             halt_o,
  output logic [$clog2(NUM_LANES+1)-1:0]   busy_cnt_o,
  output logic                             violation_o,
  output logic [$clog2(NUM_LANES)-1:0]     violation_lane_o
);

  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  localparam int LANE_W = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    LANE_FREE  = 2'd0,
    LANE_BUSY  = 2'd1,
    LANE_CLEAR = 2'd2
  } lane_state_e;

  logic [NUM_LANES-1:0] free_v;
  logic [NUM_LANES-1:0] clear_v;
  logic [NUM_LANES-1:0] hit_v;       // BUSY lane whose tag equals commit_id_i
  logic [NUM_LANES-1:0] viol_v;      // BUSY lane with any monitor bit set
  logic [NUM_LANES-1:0] occupied_d;  // lane will be non-FREE after this edge
  logic [NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0] release_v;
  logic                 fire;

  assign ins_ready_o   = (|free_v) & ~flush_i;
  assign fire          = ins_valid_i & ins_ready_o;
  assign alloc_valid_o = {NUM_LANES{fire}} & grant;
  assign alloc_itype_o = ins_itype_i;
  assign lane_reset_o  = clear_v;

  // Lowest-index FREE lane gets the grant; lowest-index tag match gets released,
  // so duplicate tags retire one lane per commit.
  always_comb begin
    grant     = '0;
    release_v = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (free_v[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
      end
      if (hit_v[k] && commit_valid_i) begin
        release_v    = '0;
        release_v[k] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_state_e     state_q, state_d;
    logic [ID_W-1:0] tag_q, tag_d;

    always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      case (state_q)
        LANE_FREE: begin
          if (fire && grant[gi]) begin
            state_d = LANE_BUSY;
            tag_d   = ins_id_i;
          end
        end
        LANE_BUSY: begin
          if (flush_i || release_v[gi]) state_d = LANE_CLEAR;
        end
        default: state_d = LANE_FREE;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= LANE_FREE;
        tag_q   <= '0;
      end else begin
        state_q <= state_d;
        tag_q   <= tag_d;
      end
    end

    assign free_v[gi]     = (state_q == LANE_FREE);
    assign clear_v[gi]    = (state_q == LANE_CLEAR);
    assign hit_v[gi]      = (state_q == LANE_BUSY) && (tag_q == commit_id_i);
    assign viol_v[gi]     = (state_q == LANE_BUSY) && (|monitor_i[gi*NUM_RULES +: NUM_RULES]);
    assign occupied_d[gi] = (state_d != LANE_FREE);
  end

  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [LANE_W-1:0] viol_lane_q, viol_lane_d;
  logic              viol_q;
  logic              halt_q;

  always_comb begin
    busy_cnt_d  = '0;
    viol_lane_d = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(occupied_d[k]);
    end
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (viol_v[k]) viol_lane_d = LANE_W'(k);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_cnt_q  <= '0;
      halt_q      <= 1'b0;
      viol_q      <= 1'b0;
      viol_lane_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      halt_q     <= stall_i;
      // Clear has priority over a violation arriving in the same cycle.
      if (viol_clr_i) begin
        viol_q      <= 1'b0;
        viol_lane_q <= '0;
      end else if (!viol_q && (|viol_v)) begin
        viol_q      <= 1'b1;
        viol_lane_q <= viol_lane_d;
      end
    end
  end

  assign busy_cnt_o       = busy_cnt_q;
  assign halt_o           = halt_q;
  assign violation_o      = viol_q;
  assign violation_lane_o = viol_lane_q;

endmodule

// File: tb/tb_rm_lane_alloc.sv
module tb_rm_lane_alloc;
  localparam int NL = 4;
  localparam int NR = 16;
  localparam int IW = 3;
  localparam int CW = $clog2(NL + 1);
  localparam int LW = $clog2(NL);

  logic clk = 1'b0;
  logic rst;
  logic ins_valid, ins_itype, ins_ready;
  logic [IW-1:0] ins_id, commit_id;
  logic commit_valid, flush, stall, viol_clr;
  logic [NL*NR-1:0] monitor;
  logic [NL-1:0] alloc_valid, lane_reset;
  logic alloc_itype, halt, violation;
  logic [CW-1:0] busy_cnt;
  logic [LW-1:0] violation_lane;

  rm_lane_alloc #(.NUM_LANES(NL), .NUM_RULES(NR), .ID_W(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .ins_valid_i(ins_valid), .ins_itype_i(ins_itype), .ins_id_i(ins_id),
    .ins_ready_o(ins_ready),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id),
    .flush_i(flush), .stall_i(stall), .monitor_i(monitor), .viol_clr_i(viol_clr),
    .alloc_valid_o(alloc_valid), .alloc_itype_o(alloc_itype),
    .lane_reset_o(lane_reset), .halt_o(halt), .busy_cnt_o(busy_cnt),
    .violation_o(violation), .violation_lane_o(violation_lane)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: lane condition 0 = free, 1 = holding an instruction, 2 = being reset.
  int          m_st [NL];
  logic [IW-1:0] m_tag [NL];
  logic        m_viol;
  int          m_vlane;
  logic        m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < NL; k++) begin
      m_st[k]  = 0;
      m_tag[k] = '0;
    end
    m_viol = 1'b0; m_vlane = 0; m_halt = 1'b0;
  endtask

  task automatic idle_inputs();
    ins_valid = 0; ins_itype = 0; ins_id = '0; commit_valid = 0; commit_id = '0;
    flush = 0; stall = 0; monitor = '0; viol_clr = 0;
  endtask

  task automatic check_regs();
    logic [NL-1:0] erst;
    int cnt;
    erst = '0; cnt = 0;
    for (int k = 0; k < NL; k++) begin
      if (m_st[k] == 2) erst[k] = 1'b1;
      if (m_st[k] != 0) cnt++;
    end
    chk("lane_reset", 32'(lane_reset), 32'(erst));
    chk("busy_cnt", 32'(busy_cnt), 32'(cnt));
    chk("halt", 32'(halt), 32'(m_halt));
    chk("violation", 32'(violation), 32'(m_viol));
    chk("violation_lane", 32'(violation_lane), 32'(m_vlane));
  endtask

  // Called just after the falling edge with inputs applied: checks combinational
  // outputs, advances the model across the rising edge, checks registered outputs.
  task automatic tick();
    int g, rel, vl;
    logic rdy;
    logic [NL-1:0] ea;
    #1;
    g = -1;
    for (int k = 0; k < NL; k++) if (m_st[k] == 0 && g < 0) g = k;
    rdy = (g >= 0) && !flush;
    ea = '0;
    if (ins_valid && rdy) ea[g] = 1'b1;
    chk("ins_ready", 32'(ins_ready), 32'(rdy));
    chk("alloc_valid", 32'(alloc_valid), 32'(ea));
    chk("alloc_itype", 32'(alloc_itype), 32'(ins_itype));
    rel = -1; vl = -1;
    for (int k = 0; k < NL; k++) begin
      if (commit_valid && m_st[k] == 1 && m_tag[k] == commit_id && rel < 0) rel = k;
      if (m_st[k] == 1 && monitor[k*NR +: NR] != '0 && vl < 0) vl = k;
    end
    if (viol_clr) begin
      m_viol = 1'b0; m_vlane = 0;
    end else if (!m_viol && vl >= 0) begin
      m_viol = 1'b1; m_vlane = vl;
    end
    for (int k = 0; k < NL; k++) begin
      if (m_st[k] == 0) begin
        if (ea[k]) begin m_st[k] = 1; m_tag[k] = ins_id; end
      end else if (m_st[k] == 1) begin
        if (flush || rel == k) m_st[k] = 2;
      end else begin
        m_st[k] = 0;
      end
    end
    m_halt = stall;
    @(negedge clk);
    check_regs();
  endtask

  task automatic issue(input logic [IW-1:0] id, input logic it);
    idle_inputs(); ins_valid = 1; ins_id = id; ins_itype = it; tick();
  endtask

  task automatic commit(input logic [IW-1:0] id);
    idle_inputs(); commit_valid = 1; commit_id = id; tick();
  endtask

  task automatic do_flush();
    idle_inputs(); flush = 1; tick();
    idle_inputs(); tick();
  endtask

  typedef struct {
    logic          itype;
    logic [IW-1:0] id;
    logic [NL-1:0] exp_alloc;
    logic          exp_ready;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b0, 3'd0, 4'b0001, 1'b1, 3'd1};
    vecs[1] = '{1'b1, 3'd1, 4'b0010, 1'b1, 3'd2};
    vecs[2] = '{1'b0, 3'd2, 4'b0100, 1'b1, 3'd3};
    vecs[3] = '{1'b1, 3'd3, 4'b1000, 1'b1, 3'd4};
    vecs[4] = '{1'b0, 3'd4, 4'b0000, 1'b0, 3'd4};

    idle_inputs();
    rst = 1'b1;
    m_reset();
    @(negedge clk); @(negedge clk);
    check_regs();
    chk("reset_alloc", 32'(alloc_valid), 32'(0));
    rst = 1'b0;
    #1;
    chk("reset_ready", 32'(ins_ready), 32'(1));

    // 1: back-to-back fill, final request blocked by full array
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      ins_valid = 1; ins_itype = vecs[i].itype; ins_id = vecs[i].id;
      #1;
      chk($sformatf("t1_alloc[%0d]", i), 32'(alloc_valid), 32'(vecs[i].exp_alloc));
      chk($sformatf("t1_ready[%0d]", i), 32'(ins_ready), 32'(vecs[i].exp_ready));
      tick();
      chk($sformatf("t1_cnt[%0d]", i), 32'(busy_cnt), 32'(vecs[i].exp_cnt));
    end

    // 2: commit id 2 with request pending; lane 2 reused two cycles later
    commit_valid = 1; commit_id = 3'd2; tick();
    chk("t2_lane_reset", 32'(lane_reset), 32'(4'b0100));
    commit_valid = 0;
    #1; chk("t2_no_alloc_in_clear", 32'(alloc_valid), 32'(0));
    tick();
    chk("t2_reset_one_cycle", 32'(lane_reset), 32'(0));
    #1; chk("t2_pending_fires", 32'(alloc_valid), 32'(4'b0100));
    tick();
    do_flush();

    // 3: flush with request present
    issue(3'd1, 1'b0); issue(3'd2, 1'b1); issue(3'd3, 1'b0);
    idle_inputs(); flush = 1; ins_valid = 1; ins_id = 3'd4;
    #1;
    chk("t3_no_alloc", 32'(alloc_valid), 32'(0));
    chk("t3_not_ready", 32'(ins_ready), 32'(0));
    tick();
    chk("t3_lane_reset", 32'(lane_reset), 32'(4'b0111));
    idle_inputs(); tick();
    chk("t3_cnt_zero", 32'(busy_cnt), 32'(0));

    // 4: violation capture, stickiness, clear priority
    issue(3'd5, 1'b0); issue(3'd6, 1'b1); commit(3'd5); idle_inputs(); tick();
    monitor = '0; monitor[1*NR + 3] = 1'b1; monitor[3*NR + 0] = 1'b1; tick();
    chk("t4_viol", 32'(violation), 32'(1));
    chk("t4_vlane", 32'(violation_lane), 32'(1));
    issue(3'd7, 1'b0);
    idle_inputs(); monitor[0*NR + 5] = 1'b1; tick();
    chk("t4_vlane_sticky", 32'(violation_lane), 32'(1));
    viol_clr = 1; tick();
    chk("t4_clr_viol", 32'(violation), 32'(0));
    chk("t4_clr_vlane", 32'(violation_lane), 32'(0));
    do_flush();

    // 5: allocation to lane 0 and commit of lane 2 in the same cycle
    issue(3'd1, 1'b0); issue(3'd2, 1'b0); issue(3'd3, 1'b1);
    commit(3'd1); commit(3'd2);
    chk("t5_cnt_before", 32'(busy_cnt), 32'(2));
    idle_inputs(); ins_valid = 1; ins_id = 3'd4; commit_valid = 1; commit_id = 3'd3;
    #1; chk("t5_alloc", 32'(alloc_valid), 32'(4'b0001));
    tick();
    chk("t5_lane_reset", 32'(lane_reset), 32'(4'b0100));
    chk("t5_cnt_same", 32'(busy_cnt), 32'(2));

    // 6: asynchronous reset while lane 1 is clearing
    idle_inputs(); tick();
    issue(3'd5, 1'b1);
    idle_inputs(); commit_valid = 1; commit_id = 3'd5; stall = 1; monitor[0] = 1'b1; tick();
    chk("t6_pre_lane_reset", 32'(lane_reset), 32'(4'b0010));
    chk("t6_pre_halt", 32'(halt), 32'(1));
    chk("t6_pre_viol", 32'(violation), 32'(1));
    #2; rst = 1'b1; idle_inputs(); m_reset();
    #1;
    check_regs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t6_no_pulse", 32'(lane_reset), 32'(0));

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      ins_valid    = ($urandom_range(0, 2) != 0);
      ins_itype    = 1'($urandom_range(0, 1));
      ins_id       = IW'($urandom_range(0, 7));
      commit_valid = ($urandom_range(0, 1) != 0);
      commit_id    = IW'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 15) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      viol_clr     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) monitor[$urandom_range(0, NL*NR-1)] = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
